// File: rtl/mem_io_arbiter_pkg.sv
// mem_io_arbiter_pkg: shared constants and types for the data-memory / IO bus arbiter
package mem_io_arbiter_pkg;
    localparam logic [21:0] IO_BASE      = 22'h3FFFFF;
    localparam logic [31:0] LED_ADDR_DEF = 32'hFFFF_FC60;
    localparam logic [31:0] SW_ADDR_DEF  = 32'hFFFF_FC70;
    typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;
    typedef enum logic [1:0] {CLS_MEM, CLS_LED, CLS_SW, CLS_UNMAPPED} cls_t;
    typedef enum logic {OWN_CPU, OWN_UART} own_t;
endpackage

// File: rtl/io_addr_decode.sv
// io_addr_decode: classifies a bus access as memory, LED write, switch read or unmapped IO
module io_addr_decode
    import mem_io_arbiter_pkg::*;
#(
    parameter logic [31:0] LED_ADDR = LED_ADDR_DEF,
    parameter logic [31:0] SW_ADDR  = SW_ADDR_DEF
) (
    input  logic [31:0] addr,
    input  logic        we,
    output cls_t        cls
);
    // writes to the switch and reads of the LED register fall through to unmapped
    assign cls = (addr[31:10] != IO_BASE)       ? CLS_MEM :
                 (we && addr == LED_ADDR)       ? CLS_LED :
                 (!we && addr == SW_ADDR)       ? CLS_SW  : CLS_UNMAPPED;
endmodule

// File: rtl/mem_io_arbiter.sv
// mem_io_arbiter: round-robin arbiter and access sequencer for the shared RAM / IO bus
module mem_io_arbiter
    import mem_io_arbiter_pkg::*;
#(
    parameter int          MEM_AW   = 14,
    parameter logic [31:0] LED_ADDR = LED_ADDR_DEF,
    parameter logic [31:0] SW_ADDR  = SW_ADDR_DEF
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [31:0]       c_addr,
    input  logic [31:0]       c_wdata,
    output logic              c_ack,
    output logic [31:0]       c_rdata,
    input  logic              u_req,
    input  logic              u_we,
    input  logic [31:0]       u_addr,
    input  logic [31:0]       u_wdata,
    output logic              u_ack,
    output logic [31:0]       u_rdata,
    input  logic              u_lock,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              led_we,
    output logic [15:0]       led_wdata,
    output logic              sw_re,
    input  logic [15:0]       sw_rdata
);
    state_t      state;
    own_t        owner, last, win;
    cls_t        cls, w_cls;
    logic        rd_pend, c_elig, u_elig, w_we, done;
    logic [31:0] w_addr, w_wdata, rdata;

    // the loader lock masks the CPU; on a tie the side not served last wins
    assign c_elig  = c_req && !u_lock;
    assign u_elig  = u_req;
    assign win     = (c_elig && u_elig) ? (last == OWN_CPU ? OWN_UART : OWN_CPU) :
                     (c_elig ? OWN_CPU : OWN_UART);
    assign w_we    = (win == OWN_CPU) ? c_we    : u_we;
    assign w_addr  = (win == OWN_CPU) ? c_addr  : u_addr;
    assign w_wdata = (win == OWN_CPU) ? c_wdata : u_wdata;

    io_addr_decode #(.LED_ADDR(LED_ADDR), .SW_ADDR(SW_ADDR)) u_dec (
        .addr(w_addr),
        .we  (w_we),
        .cls (w_cls)
    );

    // grant in IDLE, present registered bus strobes for exactly the ACCESS cycle
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= OWN_CPU;
            last      <= OWN_UART;
            cls       <= CLS_MEM;
            rd_pend   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            led_we    <= 1'b0;
            led_wdata <= '0;
            sw_re     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (c_elig || u_elig) begin
                    state     <= ACCESS;
                    owner     <= win;
                    last      <= win;
                    cls       <= w_cls;
                    rd_pend   <= (w_cls == CLS_MEM) && !w_we;
                    mem_en    <= (w_cls == CLS_MEM);
                    mem_we    <= (w_cls == CLS_MEM) && w_we;
                    mem_addr  <= (w_cls == CLS_MEM) ? w_addr[MEM_AW+1:2] : '0;
                    mem_wdata <= (w_cls == CLS_MEM && w_we) ? w_wdata : '0;
                    led_we    <= (w_cls == CLS_LED);
                    led_wdata <= (w_cls == CLS_LED) ? w_wdata[15:0] : '0;
                    sw_re     <= (w_cls == CLS_SW);
                end
                ACCESS: begin
                    state     <= rd_pend ? RDATA : IDLE;
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    led_we    <= 1'b0;
                    led_wdata <= '0;
                    sw_re     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ack and read data are decoded from registered state only; non-owners see zero
    assign done    = (state == RDATA) || (state == ACCESS && !rd_pend);
    assign rdata   = (state == RDATA) ? mem_rdata :
                     (state == ACCESS && cls == CLS_SW) ? {16'h0, sw_rdata} : '0;
    assign c_ack   = done && owner == OWN_CPU;
    assign u_ack   = done && owner == OWN_UART;
    assign c_rdata = c_ack ? rdata : '0;
    assign u_rdata = u_ack ? rdata : '0;
endmodule

// File: tb/tb_mem_io_arbiter.sv
// tb_mem_io_arbiter: randomized and directed self-checking bench for mem_io_arbiter
module tb_mem_io_arbiter;
    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        c_req = 1'b0, c_we = 1'b0, u_req = 1'b0, u_we = 1'b0, u_lock = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0, u_addr = '0, u_wdata = '0;
    logic        c_ack, u_ack, mem_en, mem_we, led_we, sw_re;
    logic [31:0] c_rdata, u_rdata, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [13:0] mem_addr;
    logic [15:0] led_wdata;
    logic [15:0] sw_rdata = '0;

    logic [31:0] ram [0:255];
    logic [31:0] model_mem [0:255];
    bit          last_u = 1'b1;
    int          errors = 0;
    int          checks = 0;

    mem_io_arbiter dut (
        .clock(clock), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack), .c_rdata(c_rdata),
        .u_req(u_req), .u_we(u_we), .u_addr(u_addr), .u_wdata(u_wdata), .u_ack(u_ack), .u_rdata(u_rdata),
        .u_lock(u_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .led_we(led_we), .led_wdata(led_wdata), .sw_re(sw_re), .sw_rdata(sw_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
            else mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    task automatic do_reset;
        @(negedge clock);
        rst_n = 1'b0;
        {c_req, c_we, u_req, u_we, u_lock} = '0;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        last_u = 1'b1;
    endtask

    task automatic txn(input bit is_u, input bit we, input logic [31:0] addr, input logic [31:0] wdata, input logic [15:0] sw);
        bit          io, led, swr, memrd;
        int          lat;
        logic        ack_o, ack_x;
        logic [31:0] exp_rd, rd_o;
        io     = (addr[31:10] == 22'h3FFFFF);
        led    = io && we && addr == 32'hFFFF_FC60;
        swr    = io && !we && addr == 32'hFFFF_FC70;
        memrd  = !io && !we;
        exp_rd = memrd ? model_mem[addr[9:2]] : swr ? {16'h0, sw} : 32'h0;
        @(negedge clock);
        sw_rdata = sw;
        if (is_u) begin u_req = 1'b1; u_we = we; u_addr = addr; u_wdata = wdata; end
        else begin c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata; end
        lat = 0;
        for (int cyc = 1; cyc <= 6 && lat == 0; cyc++) begin
            @(negedge clock);
            ack_o = is_u ? u_ack : c_ack;
            ack_x = is_u ? c_ack : u_ack;
            rd_o  = is_u ? u_rdata : c_rdata;
            checks++;
            if (ack_x !== 1'b0) begin errors++; $display("FAIL other_ack addr=%h got=%b want=0", addr, ack_x); end
            if (cyc == 1) begin
                checks++;
                if ({mem_en, mem_we, led_we, sw_re} !== {!io, !io && we, led, swr}) begin
                    errors++; $display("FAIL strobes addr=%h we=%b got=%b want=%b", addr, we, {mem_en, mem_we, led_we, sw_re}, {!io, !io && we, led, swr});
                end
                if (!io) begin
                    checks++;
                    if (mem_addr !== addr[15:2]) begin errors++; $display("FAIL mem_addr got=%h want=%h", mem_addr, addr[15:2]); end
                end
                if (!io && we) begin
                    checks++;
                    if (mem_wdata !== wdata) begin errors++; $display("FAIL mem_wdata got=%h want=%h", mem_wdata, wdata); end
                end
                if (led) begin
                    checks++;
                    if (led_wdata !== wdata[15:0]) begin errors++; $display("FAIL led_wdata got=%h want=%h", led_wdata, wdata[15:0]); end
                end
            end
            if (cyc == 2 && memrd) begin
                checks++;
                if ({mem_en, mem_we, led_we, sw_re} !== 4'b0) begin errors++; $display("FAIL rdata_strobes got=%b want=0000", {mem_en, mem_we, led_we, sw_re}); end
            end
            if (ack_o === 1'b1) begin
                lat = cyc;
                checks++;
                if (rd_o !== exp_rd) begin errors++; $display("FAIL rdata addr=%h got=%h want=%h", addr, rd_o, exp_rd); end
            end
        end
        checks++;
        if (lat != (memrd ? 2 : 1)) begin errors++; $display("FAIL latency addr=%h we=%b got=%0d want=%0d", addr, we, lat, memrd ? 2 : 1); end
        if (is_u) u_req = 1'b0; else c_req = 1'b0;
        @(negedge clock);
        checks++;
        if ({c_ack, u_ack} !== 2'b00) begin errors++; $display("FAIL ack_width got=%b want=00", {c_ack, u_ack}); end
        if (!io && we) model_mem[addr[9:2]] = wdata;
        last_u = is_u;
    endtask

    task automatic test_reset;
        do_reset();
        @(negedge clock);
        checks++;
        if ({c_ack, u_ack, mem_en, mem_we, led_we, sw_re} !== 6'b0) begin
            errors++; $display("FAIL reset_strobes got=%b want=0", {c_ack, u_ack, mem_en, mem_we, led_we, sw_re});
        end
        checks++;
        if ({c_rdata, u_rdata, mem_wdata} !== 96'b0) begin errors++; $display("FAIL reset_data got=%h want=0", {c_rdata, u_rdata, mem_wdata}); end
        checks++;
        if ({mem_addr, led_wdata} !== 30'b0) begin errors++; $display("FAIL reset_addr got=%h want=0", {mem_addr, led_wdata}); end
    endtask

    task automatic test_directed;
        txn(0, 1, 32'h0000_0010, 32'h1234_5678, 16'h0);
        txn(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0);
        txn(0, 0, 32'h0000_0010, 32'h0, 16'h0);
        txn(0, 1, 32'hFFFF_FC60, 32'h0000_A5A5, 16'h0);
        txn(1, 0, 32'hFFFF_FC70, 32'h0, 16'h00F3);
        txn(0, 0, 32'hFFFF_FC00, 32'h0, 16'hFFFF);
        txn(1, 1, 32'hFFFF_FC70, 32'h5555_AAAA, 16'h1234);
        txn(0, 0, 32'hFFFF_FC60, 32'h0, 16'h4321);
    endtask

    task automatic tie_round;
        int          c_cyc, u_cyc, exp_c, exp_u;
        logic [31:0] ca, ua, cd, ud;
        ca = {22'h0, 8'($urandom_range(0, 127)), 2'b00};
        ua = {22'h0, 8'($urandom_range(128, 255)), 2'b00};
        cd = $urandom;
        ud = $urandom;
        exp_c = last_u ? 1 : 3;
        exp_u = last_u ? 3 : 1;
        c_cyc = 0;
        u_cyc = 0;
        @(negedge clock);
        c_req = 1'b1; c_we = 1'b1; c_addr = ca; c_wdata = cd;
        u_req = 1'b1; u_we = 1'b1; u_addr = ua; u_wdata = ud;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clock);
            if (c_ack === 1'b1 && c_cyc == 0) begin c_cyc = cyc; c_req = 1'b0; end
            if (u_ack === 1'b1 && u_cyc == 0) begin u_cyc = cyc; u_req = 1'b0; end
        end
        checks++;
        if (c_cyc != exp_c || u_cyc != exp_u) begin
            errors++; $display("FAIL tie_order got c=%0d u=%0d want c=%0d u=%0d", c_cyc, u_cyc, exp_c, exp_u);
        end
        model_mem[ca[9:2]] = cd;
        model_mem[ua[9:2]] = ud;
        last_u = (exp_u == 3);
    endtask

    task automatic test_tie;
        do_reset();
        tie_round();
        tie_round();
        tie_round();
        txn(0, 0, 32'h0000_0200, 32'h0, 16'h0);
    endtask

    task automatic test_lock;
        int lat;
        @(negedge clock);
        u_lock = 1'b1;
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h0000_0040; c_wdata = 32'hC0DE_0040;
        txn(1, 1, 32'h0000_0080, 32'h0B0B_0080, 16'h0);
        txn(1, 0, 32'h0000_0080, 32'h0, 16'h0);
        txn(1, 0, 32'hFFFF_FC70, 32'h0, 16'hBEEF);
        u_lock = 1'b0;
        lat = 0;
        for (int cyc = 1; cyc <= 6 && lat == 0; cyc++) begin
            @(negedge clock);
            if (c_ack === 1'b1) lat = cyc;
        end
        checks++;
        if (lat != 1) begin errors++; $display("FAIL lock_release got=%0d want=1", lat); end
        c_req = 1'b0;
        model_mem[8'h10] = 32'hC0DE_0040;
        last_u = 1'b0;
        txn(0, 0, 32'h0000_0040, 32'h0, 16'h0);
    endtask

    task automatic test_lock_mid;
        int lat;
        @(negedge clock);
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0000_0080;
        @(negedge clock);
        u_lock = 1'b1;
        u_req = 1'b1; u_we = 1'b1; u_addr = 32'h0000_00C0; u_wdata = 32'h7777_00C0;
        @(negedge clock);
        checks++;
        if (c_ack !== 1'b1 || c_rdata !== model_mem[8'h20] || u_ack !== 1'b0) begin
            errors++; $display("FAIL lock_mid_cpu got ack=%b rdata=%h want ack=1 rdata=%h", c_ack, c_rdata, model_mem[8'h20]);
        end
        c_req = 1'b0;
        lat = 0;
        for (int cyc = 1; cyc <= 6 && lat == 0; cyc++) begin
            @(negedge clock);
            if (u_ack === 1'b1) lat = cyc;
        end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL lock_mid_uart got=%0d want=2", lat); end
        u_req = 1'b0;
        u_lock = 1'b0;
        model_mem[8'h30] = 32'h7777_00C0;
        last_u = 1'b1;
    endtask

    task automatic test_back_to_back;
        bit          rd;
        int          p, first, second;
        logic [31:0] a1, a2;
        a1 = 32'h0000_0020;
        a2 = 32'h0000_0024;
        for (int k = 0; k < 2; k++) begin
            rd = (k == 1);
            p = rd ? 3 : 2;
            first = 0;
            second = 0;
            @(negedge clock);
            c_req = 1'b1; c_we = !rd; c_addr = a1; c_wdata = 32'hAB00_0001;
            for (int cyc = 1; cyc <= 8; cyc++) begin
                @(negedge clock);
                if (c_ack === 1'b1) begin
                    if (first == 0) begin
                        first = cyc;
                        if (rd) begin
                            checks++;
                            if (c_rdata !== model_mem[a1[9:2]]) begin errors++; $display("FAIL b2b_rdata1 got=%h want=%h", c_rdata, model_mem[a1[9:2]]); end
                        end
                        c_addr = a2; c_wdata = 32'hAB00_0002;
                    end else if (second == 0) begin
                        second = cyc;
                        if (rd) begin
                            checks++;
                            if (c_rdata !== model_mem[a2[9:2]]) begin errors++; $display("FAIL b2b_rdata2 got=%h want=%h", c_rdata, model_mem[a2[9:2]]); end
                        end
                        c_req = 1'b0;
                    end
                end
            end
            checks++;
            if (first != p - 1 || second != 2 * p - 1) begin
                errors++; $display("FAIL b2b_timing rd=%b got=%0d,%0d want=%0d,%0d", rd, first, second, p - 1, 2 * p - 1);
            end
            if (!rd) begin
                model_mem[a1[9:2]] = 32'hAB00_0001;
                model_mem[a2[9:2]] = 32'hAB00_0002;
            end
            last_u = 1'b0;
        end
    endtask

    task automatic test_random;
        bit          is_u, we;
        int          op;
        logic [31:0] addr;
        for (int n = 0; n < 40; n++) begin
            is_u = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            op   = $urandom_range(0, 3);
            addr = (op < 2) ? {22'h0, 8'($urandom_range(0, 255)), 2'b00} :
                   (op == 2) ? (we ? 32'hFFFF_FC60 : 32'hFFFF_FC70) :
                   {22'h3FFFFF, 10'($urandom)};
            txn(is_u, we, addr, $urandom, 16'($urandom));
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clock);
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0000_0044;
        @(posedge clock);
        @(posedge clock);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({c_ack, u_ack, mem_en, mem_we, led_we, sw_re} !== 6'b0) begin
            errors++; $display("FAIL reset_mid_strobes got=%b want=0", {c_ack, u_ack, mem_en, mem_we, led_we, sw_re});
        end
        checks++;
        if ({c_rdata, u_rdata} !== 64'b0) begin errors++; $display("FAIL reset_mid_data got=%h want=0", {c_rdata, u_rdata}); end
        @(negedge clock);
        c_req = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        last_u = 1'b1;
        txn(0, 1, 32'h0000_0044, 32'h4444_5555, 16'h0);
        txn(1, 0, 32'h0000_0044, 32'h0, 16'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0101;
            model_mem[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0101;
        end
        test_reset();
        test_directed();
        test_tie();
        test_lock();
        test_lock_mid();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_io_arbiter.md
# mem_io_arbiter

Sequencer and arbiter for the shared data-memory / IO bus. Two requesters (CPU load/store port and the UART program loader) share one synchronous data RAM plus the LED and switch peripherals. The block decodes each address to memory or IO, grants one requester at a time, and sequences the one-cycle RAM read latency. It returns an ack pulse that the CPU uses as its stall release.

## Interface
Parameters:
- MEM_AW, 14, word-address width of data RAM (64 KiB)
- LED_ADDR, 32'hFFFF_FC60, LED register address
- SW_ADDR, 32'hFFFF_FC70, switch register address

Ports:
- clock  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- c_req, c_we  in  1  CPU request / write-not-read
- c_addr, c_wdata  in  32  CPU byte address / write data
- c_ack  out  1  one-cycle completion pulse to CPU
- c_rdata  out  32  CPU read data, valid while c_ack=1
- u_req, u_we, u_addr, u_wdata, u_ack, u_rdata: same as c_*, for the UART loader
- u_lock  in  1  loader session active; CPU requests are not granted while high
- mem_en, mem_we  out  1  RAM enable / write enable
- mem_addr  out  MEM_AW  RAM word address (addr[MEM_AW+1:2])
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid one cycle after mem_en with mem_we=0
- led_we  out  1  LED chip select / write strobe
- led_wdata  out  16  LED data (wdata[15:0])
- sw_re  out  1  switch chip select
- sw_rdata  in  16  switch value (combinational)

## Operation
- Decode: IO space when addr[31:10]==22'h3FFFFF; otherwise memory. An IO address other than LED_ADDR or SW_ADDR is unmapped: it gets an ack, rdata=0, and causes no strobe. A write to SW_ADDR and a read of LED_ADDR are treated as unmapped.
- Requester contract: req, we, addr and wdata are held stable from assertion until the ack cycle. req is dropped, or a new transaction presented, the cycle after ack.
- FSM states:
  - IDLE → ACCESS when an eligible req is present. The winner is latched in the `owner` register.
  - ACCESS → IDLE for writes, IO reads and unmapped accesses. ack is asserted in ACCESS.
  - ACCESS → RDATA for a memory read. ack is asserted in RDATA, then the FSM returns to IDLE.
- Arbitration in IDLE:
  - If u_lock=1, only the UART requester is eligible.
  - If both requesters are eligible, round-robin applies: the requester not served last wins. The `last` register resets to UART, so the CPU wins the first tie.
  - The winner holds the bus until its ack; there is no preemption.
- Bus outputs are driven only in ACCESS, decoded from the owner's latched request:
  - mem_en=1 for memory accesses.
  - mem_we=we for memory accesses.
  - led_we=1 for a LED write.
  - sw_re=1 for a switch read.
- Read data is zero-extended:
  - c_rdata/u_rdata = mem_rdata in RDATA.
  - c_rdata/u_rdata = {16'b0, sw_rdata} in ACCESS for a switch read.
  - c_rdata/u_rdata = 0 otherwise.
  - Only the owner's ack and rdata are non-zero.
- u_lock rising mid-transaction does not abort a CPU transaction already in progress. It takes effect at the next IDLE.

## Timing
- Reset: every output is 0, FSM is IDLE, owner=CPU, last=UART.
- Latency from req first seen in IDLE (cycle 0):
  - Memory write: ack in cycle 1.
  - IO read/write: ack in cycle 1.
  - Memory read: ack in cycle 2.
- Throughput: back-to-back writes every 2 cycles; back-to-back memory reads every 3 cycles.
- ack is exactly one cycle wide and never asserted in IDLE.
- Simultaneous c_req and u_req are resolved in the same IDLE cycle by round-robin. The loser waits with no ack.
- rst_n asserted mid-transaction:
  - All outputs drop to 0 asynchronously; no ack is issued.
  - Requesters restart after reset release.
- mem_* and led_*/sw_re are registered-state-decoded (Moore). No combinational path from c_req/u_req to any bus strobe.

## Structure
- Shared package holds:
  - IO base constant 22'h3FFFFF.
  - LED_ADDR and SW_ADDR.
  - FSM state encoding (IDLE, ACCESS, RDATA; 2 bits).
  - Decode-class enum (MEM, LED, SW, UNMAPPED).
- One sub-module: `io_addr_decode`, a combinational address plus we to decode class, also reused by the CPU's MemOrIO path. Arbiter and FSM live in the top module.

## Test plan
- CPU write 32'h1234_5678 to 0x0000_0010 → cycle 1: mem_en=1, mem_we=1, mem_addr=4, mem_wdata=32'h1234_5678, c_ack=1.
- CPU read of 0x10 with RAM returning 32'hDEAD_BEEF → c_ack only in cycle 2, with c_rdata=32'hDEAD_BEEF.
- CPU write 32'h0000_A5A5 to 0xFFFF_FC60 → led_we=1 and led_wdata=16'hA5A5 for one cycle. UART read of 0xFFFF_FC70 with switches 16'h00F3 → u_rdata=32'h0000_00F3.
- c_req and u_req together in IDLE from reset → CPU served first, UART next. The next tie goes to CPU again after UART is served.
- u_lock=1 with CPU pending → CPU never acked while UART transactions complete. Unmapped 0xFFFF_FC00 read → ack with rdata=0 and no strobes. rst_n pulled low during RDATA → all outputs 0, no ack, IDLE after release.
